// File: rtl/spi_reg_slave.sv
// SPI mode-0 register-file responder, fully oversampled in the system clock domain.
// Define SPI_REG_SLAVE_AUTOINC_EN to auto-increment the address after each data byte.
module spi_reg_slave #(
   parameter int unsigned NUM_REGS  = 4,
   parameter logic [7:0]  RESET_VAL = 8'h00
) (
   input  logic                    io_systemClk,
   input  logic                    io_systemReset,
   input  logic                    spi_sclk,
   input  logic                    spi_ss,
   input  logic                    spi_mosi,
   output logic                    spi_miso,
   output logic                    spi_miso_oe,
   output logic [NUM_REGS*8-1:0]   regs_out,
   output logic                    wr_strobe,
   output logic [6:0]              wr_addr,
   output logic [7:0]              wr_data,
   output logic                    busy
);

   localparam int unsigned AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CMD  = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;

   logic [1:0]                state_q, state_d;
   logic [2:0]                sclk_sync_q, ss_sync_q;
   logic [1:0]                mosi_sync_q;
   logic [2:0]                bit_cnt_q, bit_cnt_d;
   logic [7:0]                sh_q, sh_d;
   logic [7:0]                tx_q, tx_d;
   logic                      load_q, load_d;
   logic                      rw_q, rw_d;
   logic [6:0]                addr_q, addr_d;
   logic                      miso_q, miso_d;
   logic                      oe_q, oe_d;
   logic                      busy_q, busy_d;
   logic                      wr_strobe_q;
   logic [6:0]                wr_addr_q;
   logic [7:0]                wr_data_q;
   logic [NUM_REGS-1:0][7:0]  regs_q;

   logic                      sclk_rise_c, sclk_fall_c, ss_rise_c, ss_fall_c;
   logic                      addr_ok_c, wr_en_c;
   logic [AW-1:0]             idx_c;
   logic [7:0]                rx_byte_c, rd_val_c;

   // Edges are taken between the second synchroniser stage and the history stage
   assign sclk_rise_c = sclk_sync_q[1] & ~sclk_sync_q[2];
   assign sclk_fall_c = ~sclk_sync_q[1] & sclk_sync_q[2];
   assign ss_rise_c   = ss_sync_q[1] & ~ss_sync_q[2];
   assign ss_fall_c   = ~ss_sync_q[1] & ss_sync_q[2];

   assign addr_ok_c = (32'(addr_q) < NUM_REGS);
   assign idx_c     = addr_q[AW-1:0];
   assign rx_byte_c = {sh_q[6:0], mosi_sync_q[1]};
   assign rd_val_c  = (rw_q && addr_ok_c) ? regs_q[idx_c] : 8'h00;

   // Next-state and datapath decode
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      sh_d      = sh_q;
      tx_d      = tx_q;
      load_d    = load_q;
      rw_d      = rw_q;
      addr_d    = addr_q;
      miso_d    = miso_q;
      oe_d      = oe_q;
      wr_en_c   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (ss_fall_c) begin
               state_d   = ST_CMD;
               bit_cnt_d = 3'd0;
               sh_d      = 8'h00;
               tx_d      = 8'h00;
               load_d    = 1'b0;
               miso_d    = 1'b0;
               oe_d      = 1'b1;
            end
         end
         ST_CMD, ST_DATA: begin
            if (ss_rise_c) begin
               state_d   = ST_IDLE;
               bit_cnt_d = 3'd0;
               tx_d      = 8'h00;
               load_d    = 1'b0;
               miso_d    = 1'b0;
               oe_d      = 1'b0;
            end else begin
               if (sclk_rise_c) begin
                  sh_d      = rx_byte_c;
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     load_d = 1'b1;
                     if (state_q == ST_CMD) begin
                        state_d = ST_DATA;
                        rw_d    = rx_byte_c[7];
                        addr_d  = rx_byte_c[6:0];
                     end else begin
                        wr_en_c = ~rw_q & addr_ok_c;
`ifdef SPI_REG_SLAVE_AUTOINC_EN
                        addr_d  = addr_q + 7'd1;
`else
                        addr_d  = addr_q;
`endif
                     end
                  end
               end
               // A pending load replaces the shifter with the next read byte
               if (sclk_fall_c) begin
                  if (load_q) begin
                     miso_d = rd_val_c[7];
                     tx_d   = {rd_val_c[6:0], 1'b0};
                     load_d = 1'b0;
                  end else begin
                     miso_d = tx_q[7];
                     tx_d   = {tx_q[6:0], 1'b0};
                  end
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            miso_d  = 1'b0;
            oe_d    = 1'b0;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // Sync FFs reset low so a held-low select cannot look like a falling edge
   always_ff @(posedge io_systemClk) begin
      if (io_systemReset) begin
         state_q     <= ST_IDLE;
         sclk_sync_q <= 3'b000;
         ss_sync_q   <= 3'b000;
         mosi_sync_q <= 2'b00;
         bit_cnt_q   <= 3'd0;
         sh_q        <= 8'h00;
         tx_q        <= 8'h00;
         load_q      <= 1'b0;
         rw_q        <= 1'b0;
         addr_q      <= 7'd0;
         miso_q      <= 1'b0;
         oe_q        <= 1'b0;
         busy_q      <= 1'b0;
         wr_strobe_q <= 1'b0;
         wr_addr_q   <= 7'd0;
         wr_data_q   <= 8'h00;
         regs_q      <= {NUM_REGS{RESET_VAL}};
      end else begin
         state_q     <= state_d;
         sclk_sync_q <= {sclk_sync_q[1:0], spi_sclk};
         ss_sync_q   <= {ss_sync_q[1:0], spi_ss};
         mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
         bit_cnt_q   <= bit_cnt_d;
         sh_q        <= sh_d;
         tx_q        <= tx_d;
         load_q      <= load_d;
         rw_q        <= rw_d;
         addr_q      <= addr_d;
         miso_q      <= miso_d;
         oe_q        <= oe_d;
         busy_q      <= busy_d;
         wr_strobe_q <= wr_en_c;
         if (wr_en_c) begin
            wr_addr_q      <= addr_q;
            wr_data_q      <= rx_byte_c;
            regs_q[idx_c]  <= rx_byte_c;
         end
      end
   end

   assign spi_miso    = miso_q;
   assign spi_miso_oe = oe_q;
   assign busy        = busy_q;
   assign wr_strobe   = wr_strobe_q;
   assign wr_addr     = wr_addr_q;
   assign wr_data     = wr_data_q;
   assign regs_out    = regs_q;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Self-checking bench for spi_reg_slave: directed table, corner sequences and
// random transactions compared against a transaction-level register model.
module tb_spi_reg_slave;

   localparam int unsigned NREGS = 4;
   localparam int          HALF  = 8;

   typedef logic [7:0]  bq_t[$];
   typedef logic [14:0] sq_t[$];
   typedef struct {
      logic [7:0] b0;
      logic [7:0] b1;
      logic [7:0] exp_rd;
      int         exp_nwr;
   } vec_t;

   logic        clk  = 1'b0;
   logic        rst  = 1'b1;
   logic        sclk = 1'b0;
   logic        ss   = 1'b1;
   logic        mosi = 1'b0;
   logic        miso, oe, strobe, busy;
   logic [31:0] regs_out;
   logic [6:0]  wr_addr;
   logic [7:0]  wr_data;

   int          n_vec = 0;
   int          n_err = 0;
   logic [7:0]  mregs [128];
   sq_t         got_q;

   spi_reg_slave #(.NUM_REGS(NREGS), .RESET_VAL(8'h00)) dut (
      .io_systemClk   (clk),
      .io_systemReset (rst),
      .spi_sclk       (sclk),
      .spi_ss         (ss),
      .spi_mosi       (mosi),
      .spi_miso       (miso),
      .spi_miso_oe    (oe),
      .regs_out       (regs_out),
      .wr_strobe      (strobe),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   // Every high cycle of the strobe is logged, so a stretched pulse shows up twice
   always @(negedge clk) if (strobe) got_q.push_back({wr_addr, wr_data});

   task automatic half_bit();
      repeat (HALF) @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic xfer_byte(input logic [7:0] tx, output logic [7:0] rx);
      for (int i = 7; i >= 0; i--) begin
         mosi = tx[i];
         half_bit();
         rx[i] = miso;
         sclk = 1'b1;
         half_bit();
         sclk = 1'b0;
      end
   endtask

   task automatic xfer_bits(input int n, input logic [7:0] pat);
      for (int i = 0; i < n; i++) begin
         mosi = pat[7-i];
         half_bit();
         sclk = 1'b1;
         half_bit();
         sclk = 1'b0;
      end
   endtask

   function automatic logic [31:0] model_regs();
      return {mregs[3], mregs[2], mregs[1], mregs[0]};
   endfunction

   // Transaction-level model: only whole data bytes after the command take effect
   task automatic model_txn(input bq_t tx, output bq_t exp_rx, output sq_t exp_wr);
      logic       rw;
      logic [6:0] a;
      exp_rx = {};
      exp_wr = {};
      if (tx.size() == 0) return;
      exp_rx.push_back(8'h00);
      rw = tx[0][7];
      a  = tx[0][6:0];
      for (int k = 1; k < tx.size(); k++) begin
         if (rw) begin
            exp_rx.push_back((32'(a) < NREGS) ? mregs[a] : 8'h00);
         end else begin
            exp_rx.push_back(8'h00);
            if (32'(a) < NREGS) begin
               mregs[a] = tx[k];
               exp_wr.push_back({a, tx[k]});
            end
         end
`ifdef SPI_REG_SLAVE_AUTOINC_EN
         a = a + 7'd1;
`endif
      end
   endtask

   task automatic run_txn(input bq_t tx, input int partial, output bq_t rx);
      logic [7:0] r;
      rx    = {};
      got_q = {};
      ss = 1'b0;
      half_bit();
      chk("oe_selected", 32'(oe), 32'd1);
      chk("busy_selected", 32'(busy), 32'd1);
      foreach (tx[i]) begin
         xfer_byte(tx[i], r);
         rx.push_back(r);
      end
      if (partial > 0) xfer_bits(partial, 8'h96);
      half_bit();
      ss = 1'b1;
      half_bit();
      half_bit();
      chk("oe_idle", 32'(oe), 32'd0);
      chk("busy_idle", 32'(busy), 32'd0);
   endtask

   task automatic txn(input bq_t tx, input int partial, output bq_t rx);
      bq_t exp_rx;
      sq_t exp_wr;
      model_txn(tx, exp_rx, exp_wr);
      run_txn(tx, partial, rx);
      foreach (exp_rx[i]) if (i < rx.size()) chk($sformatf("miso_byte%0d", i), 32'(rx[i]), 32'(exp_rx[i]));
      chk("wr_count", 32'(got_q.size()), 32'(exp_wr.size()));
      foreach (exp_wr[i]) if (i < got_q.size()) chk($sformatf("wr_addr_data%0d", i), 32'(got_q[i]), 32'(exp_wr[i]));
      chk("regs_out", regs_out, model_regs());
   endtask

   initial begin
      vec_t       vt [8];
      bq_t        tx, rx;
      logic [7:0] dummy;
      logic [7:0] reg1_before;

      foreach (mregs[i]) mregs[i] = 8'h00;
      vt[0] = '{8'h02, 8'hA5, 8'h00, 1};
      vt[1] = '{8'h82, 8'h00, 8'hA5, 0};
      vt[2] = '{8'h05, 8'hFF, 8'h00, 0};
      vt[3] = '{8'h85, 8'h00, 8'h00, 0};
      vt[4] = '{8'h03, 8'h7E, 8'h00, 1};
      vt[5] = '{8'h83, 8'h00, 8'h7E, 0};
      vt[6] = '{8'h80, 8'h00, 8'h00, 0};
      vt[7] = '{8'h82, 8'h55, 8'hA5, 0};

      // Reset state
      repeat (4) @(negedge clk);
      chk("rst_miso", 32'(miso), 32'd0);
      chk("rst_oe", 32'(oe), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_strobe", 32'(strobe), 32'd0);
      chk("rst_regs", regs_out, 32'h0);
      rst = 1'b0;
      repeat (8) @(negedge clk);

      // Directed two-byte transactions
      for (int i = 0; i < 8; i++) begin
         tx = {vt[i].b0, vt[i].b1};
         txn(tx, 0, rx);
         chk($sformatf("vec%0d_rd", i), 32'(rx[1]), 32'(vt[i].exp_rd));
         chk($sformatf("vec%0d_nwr", i), 32'(got_q.size()), 32'(vt[i].exp_nwr));
      end
      chk("reg2_after_table", 32'(regs_out[23:16]), 32'hA5);

      // Burst write
      tx = {8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
      txn(tx, 0, rx);
      chk("burst_nwr", 32'(got_q.size()), 32'd4);
`ifdef SPI_REG_SLAVE_AUTOINC_EN
      chk("burst_regs", regs_out, 32'h44332211);
`else
      chk("burst_reg0", 32'(regs_out[7:0]), 32'h44);
`endif

      // Burst read of the same registers
      tx = {8'h80, 8'h00, 8'h00, 8'h00, 8'h00};
      txn(tx, 0, rx);

      // Abort after five data bits, then a clean write
      reg1_before = regs_out[15:8];
      tx = {8'h01};
      txn(tx, 5, rx);
      chk("abort_reg1", 32'(regs_out[15:8]), 32'(reg1_before));
      tx = {8'h01, 8'h3C};
      txn(tx, 0, rx);
      chk("after_abort_reg1", 32'(regs_out[15:8]), 32'h3C);

      // Reset mid-transaction with select held low
      got_q = {};
      ss = 1'b0;
      half_bit();
      xfer_byte(8'h00, dummy);
      xfer_bits(3, 8'hFF);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_miso", 32'(miso), 32'd0);
      chk("mid_rst_oe", 32'(oe), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_strobe", 32'(strobe), 32'd0);
      chk("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
      chk("mid_rst_wr_data", 32'(wr_data), 32'd0);
      chk("mid_rst_regs", regs_out, 32'h0);
      rst = 1'b0;
      foreach (mregs[i]) mregs[i] = 8'h00;
      xfer_bits(5, 8'hFF);
      xfer_byte(8'h5A, dummy);
      half_bit();
      chk("ignored_busy", 32'(busy), 32'd0);
      chk("ignored_oe", 32'(oe), 32'd0);
      chk("ignored_nwr", 32'(got_q.size()), 32'd0);
      chk("ignored_regs", regs_out, 32'h0);
      ss = 1'b1;
      half_bit();
      half_bit();
      tx = {8'h00, 8'h5A};
      txn(tx, 0, rx);
      chk("post_rst_reg0", 32'(regs_out[7:0]), 32'h5A);

      // Random transactions, some aborted mid-byte
      for (int n = 0; n < 30; n++) begin
         logic [6:0] a;
         int         nd, part;
         a = ($urandom_range(0, 3) == 0) ? 7'(125 + $urandom_range(0, 2)) : 7'($urandom_range(0, 7));
         nd   = $urandom_range(1, 3);
         part = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 7) : 0;
         tx = {};
         tx.push_back({1'($urandom_range(0, 1)), a});
         for (int k = 0; k < nd; k++) tx.push_back(8'($urandom()));
         txn(tx, part, rx);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
